// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: single transfers of byte/half/word size with optional
// wait states and a two-cycle ERROR response for out-of-range or misaligned accesses.
module ahb_sram_slave #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hsel,
    input  logic [1:0]            htrans,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic                  hmastlock,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready_in,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [DATA_WIDTH-1:0] hrdata
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] WIN_BYTES = (ADDR_WIDTH+1)'(4 * MEM_DEPTH);
    localparam logic [2:0] WS = 3'(WAIT_STATES);

    // state  | meaning
    // S_IDLE | no transfer in data phase, ready/OKAY
    // S_WAIT | inserting wait states, hreadyout low
    // S_DATA | data phase completes this cycle
    // S_ERR1 | first ERROR cycle, hreadyout low
    // S_ERR2 | second ERROR cycle, hreadyout high
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [IDX_W+1:0]   addr_q;
    logic               hwrite_q;
    logic [1:0]         hsize_q;
    logic               hreadyout_q;
    logic               hresp_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] addr_off;
    logic                  in_range;
    logic                  addr_err;
    logic                  can_accept;
    logic                  accept;
    logic [3:0]            lane_en;

    logic unused_ok;
    assign unused_ok = ^{hburst, hprot, hmastlock};

    assign addr_off = haddr - BASE_ADDR;
    assign in_range = (haddr >= BASE_ADDR) && ({1'b0, addr_off} < WIN_BYTES);

    assign addr_err = !in_range
                   || (hsize > 3'b010)
                   || ((hsize == 3'b001) && haddr[0])
                   || ((hsize == 3'b010) && (haddr[1:0] != 2'b00));

    // Address phases are only taken when no other data phase is still pending.
    assign can_accept = (state_q == S_IDLE) || (state_q == S_DATA);
    assign accept     = can_accept && hsel && htrans[1] && hready_in;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DATA: begin
                if (accept) begin
                    if (addr_err) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WS;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = S_DATA;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            S_ERR2:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hreadyout_q <= (state_d != S_WAIT) && (state_d != S_ERR1);
            hresp_q     <= (state_d == S_ERR1) || (state_d == S_ERR2);
            if (accept) begin
                addr_q   <= addr_off[IDX_W+1:0];
                hwrite_q <= hwrite;
                hsize_q  <= hsize[1:0];
            end
        end
    end

    always_comb begin
        case (hsize_q)
            2'b00:   lane_en = 4'b0001 << addr_q[1:0];
            2'b01:   lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    // Memory is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if ((state_q == S_DATA) && hwrite_q) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[addr_q[IDX_W+1:2]][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    assign hreadyout = hreadyout_q;
    assign hresp     = hresp_q;
    assign hrdata    = ((state_q == S_DATA) && !hwrite_q) ? mem[addr_q[IDX_W+1:2]] : '0;

endmodule
